// File: rtl/core_pkg.sv
// Shared core definitions: forwarding select encodings and the destination tag
// that the hazard controller carries down its shadow pipeline.
package core_pkg;

  localparam int REG_W = 3;

  // Execute-stage operand select encodings (execute decodes the same values)
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/fwd_sel.sv
// Forward select for one source operand of the instruction about to enter EX.
// The tags are sampled one stage before they matter: the ID/EX producer will sit
// in EX/MEM next cycle, and the EX/MEM producer will sit in MEM/WB.
module fwd_sel
  import core_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             src_used,
  input  tag_t             idex,
  input  tag_t             exmem,
  output logic [1:0]       sel
);

  // The youngest producer wins; a load in ID/EX is never a forward source,
  // because the load-use stall moves it one stage further first.
  always_comb begin
    sel = FWD_REG;
    if (src_used && idex.valid && idex.regwrite && !idex.memread && src == idex.rd)
      sel = FWD_EXMEM;
    else if (src_used && exmem.valid && exmem.regwrite && src == exmem.rd)
      sel = FWD_MEMWB;
  end

  // An older load forwards like any other result once it reaches MEM/WB
  logic unused_memread;
  assign unused_memread = exmem.memread;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage core. Tracks destination
// tags for ID/EX, EX/MEM and MEM/WB, produces registered forward selects for
// execute, the load-use stall, the redirect flush and saturating statistics.
module hazard_fwd_ctrl
  import core_pkg::*;
#(
  parameter int REG_W = core_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pipe_en,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_used,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_redirect,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  tag_t       t_idex, t_exmem, t_memwb;
  tag_t       dec_tag;
  logic [1:0] sel_a, sel_b;
  logic       load_use, bubble;

  assign dec_tag = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};

  // Load in EX whose result the decode instruction reads; a redirect kills the
  // consumer anyway, so it suppresses the stall.
  always_comb begin
    load_use = t_idex.valid && t_idex.memread && t_idex.regwrite &&
               ((id_rs_used && id_rs == t_idex.rd) || (id_rt_used && id_rt == t_idex.rd));
    stall    = id_valid && load_use && !ex_redirect;
    flush    = ex_redirect && pipe_en;
    bubble   = stall || ex_redirect || !id_valid;
  end

  fwd_sel u_fwd_a (
    .src      (id_rs),
    .src_used (id_rs_used),
    .idex     (t_idex),
    .exmem    (t_exmem),
    .sel      (sel_a)
  );

  fwd_sel u_fwd_b (
    .src      (id_rt),
    .src_used (id_rt_used),
    .idex     (t_idex),
    .exmem    (t_exmem),
    .sel      (sel_b)
  );

  // Shadow tag pipeline, forward select registers and statistics; all frozen
  // while pipe_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_idex    <= '0;
      t_exmem   <= '0;
      t_memwb   <= '0;
      forwardA  <= FWD_REG;
      forwardB  <= FWD_REG;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (pipe_en) begin
      t_memwb  <= t_exmem;
      t_exmem  <= t_idex;
      t_idex   <= bubble ? '0 : dec_tag;
      forwardA <= bubble ? FWD_REG : sel_a;
      forwardB <= bubble ? FWD_REG : sel_b;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Register file is write-through, so the MEM/WB tag never drives a forward;
  // it is kept so the shadow pipeline mirrors the core stage for stage.
  logic unused_memwb;
  assign unused_memwb = ^t_memwb;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed per-cycle table, hand sequences for
// saturation and mid-stream reset, then random traffic against a model that
// finds the youngest in-flight writer of each source register.
module tb_hazard_fwd_ctrl;

  logic clk = 1'b0, rst_n = 1'b0;
  logic pipe_en = 1'b0, id_valid = 1'b0, id_rs_used = 1'b0, id_rt_used = 1'b0;
  logic id_regwrite = 1'b0, id_memread = 1'b0, ex_redirect = 1'b0;
  logic [2:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic [1:0] fa, fb, s_fa, s_fb;
  logic stall, flush, s_stall, s_flush;
  logic [15:0] sc, fc;
  logic [2:0] s_sc, s_fc;

  always #5 clk = ~clk;

  hazard_fwd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_redirect(ex_redirect), .forwardA(fa), .forwardB(fb), .stall(stall),
    .flush(flush), .stall_cnt(sc), .flush_cnt(fc));

  // Narrow counters so saturation is reachable in a short run
  hazard_fwd_ctrl #(.CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_redirect(ex_redirect), .forwardA(s_fa), .forwardB(s_fb), .stall(s_stall),
    .flush(s_flush), .stall_cnt(s_sc), .flush_cnt(s_fc));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {bit v; int rd; bit rw; bit ld;} ins_t;
  ins_t m_ex, m_mem;
  int   m_fa, m_fb, m_sc, m_fc;
  bit   m_stall, m_flush;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // 1 = youngest writer of r is in EX now, 2 = in MEM now, 0 = none in flight
  function automatic int age(input int r);
    if (m_ex.v && m_ex.rw && m_ex.rd == r) return 1;
    if (m_mem.v && m_mem.rw && m_mem.rd == r) return 2;
    return 0;
  endfunction

  function automatic int pick(input bit used, input int r);
    if (!used) return 0;
    case (age(r))
      1: return 2;
      2: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_ex = '{0, 0, 0, 0}; m_mem = '{0, 0, 0, 0};
    m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_comb();
    bit lu;
    lu = (id_rs_used && age(int'(id_rs)) == 1 && m_ex.ld) ||
         (id_rt_used && age(int'(id_rt)) == 1 && m_ex.ld);
    m_stall = id_valid && lu && !ex_redirect;
    m_flush = ex_redirect && pipe_en;
  endtask

  task automatic model_edge();
    bit enter;
    if (!pipe_en) return;
    enter = id_valid && !m_stall && !ex_redirect;
    m_fa  = enter ? pick(id_rs_used, int'(id_rs)) : 0;
    m_fb  = enter ? pick(id_rt_used, int'(id_rt)) : 0;
    m_mem = m_ex;
    m_ex  = '{enter, int'(id_rd), id_regwrite, id_memread};
    if (m_stall) m_sc++;
    if (m_flush) m_fc++;
  endtask

  task automatic drv(input bit pe, input bit v, input int rs, input bit rsu, input int rt,
                     input bit rtu, input int rd, input bit rw, input bit mr, input bit rdir);
    pipe_en = pe; id_valid = v; id_rs = 3'(rs); id_rs_used = rsu; id_rt = 3'(rt);
    id_rt_used = rtu; id_rd = 3'(rd); id_regwrite = rw; id_memread = mr; ex_redirect = rdir;
  endtask

  // One clock: check combinational outputs, take the edge, check registered ones
  task automatic cycle(output logic o_st, output logic o_fl);
    #1;
    model_comb();
    o_st = stall; o_fl = flush;
    chk("stall", stall, m_stall);
    chk("flush", flush, m_flush);
    chk("s_stall", s_stall, m_stall);
    chk("s_flush", s_flush, m_flush);
    @(posedge clk);
    model_edge();
    #1;
    chk("forwardA", fa, m_fa);
    chk("forwardB", fb, m_fb);
    chk("stall_cnt", sc, sat(m_sc, 65535));
    chk("flush_cnt", fc, sat(m_fc, 65535));
    chk("s_forwardA", s_fa, m_fa);
    chk("s_forwardB", s_fb, m_fb);
    chk("s_stall_cnt", s_sc, sat(m_sc, 7));
    chk("s_flush_cnt", s_fc, sat(m_fc, 7));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit pe, v; int rs; bit rsu; int rt; bit rtu; int rd; bit rw, mr, rdir;
    bit e_st, e_fl; int e_fa, e_fb, e_sc, e_fc;
  } vec_t;

  function automatic vec_t mk(input bit pe, v, input int rs, input bit rsu, input int rt,
                              input bit rtu, input int rd, input bit rw, mr, rdir, e_st, e_fl,
                              input int e_fa, e_fb, e_sc, e_fc);
    vec_t r;
    r = '{pe, v, rs, rsu, rt, rtu, rd, rw, mr, rdir, e_st, e_fl, e_fa, e_fb, e_sc, e_fc};
    return r;
  endfunction

  vec_t tbl[24];

  initial begin
    logic st, fl;

    //           pe v  rs u  rt u  rd w m rd  st fl fa fb sc fc
    tbl[0]  = mk(1, 1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); // ADD R1,R2,R3
    tbl[1]  = mk(1, 1, 1, 1, 3, 1, 2, 1, 0, 0, 0, 0, 2, 0, 0, 0); // ADD R2,R1,R3
    tbl[2]  = mk(1, 1, 6, 1, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); // ADD R1,R6,R7
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // NOP
    tbl[4]  = mk(1, 1, 5, 1, 1, 1, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0); // SUB R4,R5,R1
    tbl[5]  = mk(1, 1, 6, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0); // LD R1
    tbl[6]  = mk(1, 1, 1, 1, 1, 1, 2, 1, 0, 0, 1, 0, 0, 0, 1, 0); // ADD R2,R1,R1 stalls
    tbl[7]  = mk(1, 1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 1, 1, 1, 0); // replayed, 01/01
    tbl[8]  = mk(1, 1, 6, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0); // LD R1
    tbl[9]  = mk(1, 1, 1, 1, 1, 1, 3, 1, 0, 1, 0, 1, 0, 0, 1, 1); // use + redirect
    tbl[10] = mk(1, 1, 6, 1, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1); // ADD R1
    tbl[11] = mk(1, 1, 6, 1, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1); // ADD R1
    tbl[12] = mk(1, 1, 1, 1, 5, 1, 2, 1, 0, 0, 0, 0, 2, 0, 1, 1); // youngest wins
    tbl[13] = mk(1, 1, 6, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 1, 1); // LD R3
    tbl[14] = mk(0, 1, 3, 1, 0, 1, 4, 1, 0, 0, 1, 0, 0, 0, 1, 1); // frozen load-use
    tbl[15] = mk(0, 1, 3, 1, 0, 1, 4, 1, 0, 0, 1, 0, 0, 0, 1, 1);
    tbl[16] = mk(0, 1, 3, 1, 0, 1, 4, 1, 0, 0, 1, 0, 0, 0, 1, 1);
    tbl[17] = mk(1, 1, 3, 1, 0, 1, 4, 1, 0, 0, 1, 0, 0, 0, 2, 1); // stall counted
    tbl[18] = mk(1, 1, 3, 1, 0, 1, 4, 1, 0, 0, 0, 0, 1, 0, 2, 1);
    tbl[19] = mk(0, 1, 4, 1, 4, 1, 5, 1, 0, 0, 0, 0, 1, 0, 2, 1); // freeze holds 01
    tbl[20] = mk(0, 1, 4, 1, 4, 1, 5, 1, 0, 0, 0, 0, 1, 0, 2, 1);
    tbl[21] = mk(1, 1, 4, 1, 4, 1, 5, 1, 0, 0, 0, 0, 2, 2, 2, 1);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 2, 2, 1); // frozen redirect
    tbl[23] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2, 2);

    // Reset state
    model_reset();
    #2;
    chk("rst_forwardA", fa, 0);
    chk("rst_forwardB", fb, 0);
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_stall_cnt", sc, 0);
    chk("rst_flush_cnt", fc, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drv(tbl[i].pe, tbl[i].v, tbl[i].rs, tbl[i].rsu, tbl[i].rt, tbl[i].rtu,
          tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].rdir);
      cycle(st, fl);
      chk($sformatf("row%0d_stall", i), st, tbl[i].e_st);
      chk($sformatf("row%0d_flush", i), fl, tbl[i].e_fl);
      chk($sformatf("row%0d_fwdA", i), fa, tbl[i].e_fa);
      chk($sformatf("row%0d_fwdB", i), fb, tbl[i].e_fb);
      chk($sformatf("row%0d_scnt", i), sc, tbl[i].e_sc);
      chk($sformatf("row%0d_fcnt", i), fc, tbl[i].e_fc);
    end

    // Eight more load-use stalls: narrow counter pins at all-ones
    for (int k = 0; k < 8; k++) begin
      drv(1, 1, 6, 1, 0, 0, 1, 1, 1, 0); cycle(st, fl);
      drv(1, 1, 1, 1, 1, 1, 2, 1, 0, 0); cycle(st, fl);
      chk("sat_loop_stall", st, 1);
      cycle(st, fl);
    end
    chk("sat_small_cnt", s_sc, 7);
    chk("sat_main_cnt", sc, 10);

    // Mid-stream reset with a load-use pending
    drv(1, 1, 6, 1, 0, 0, 1, 1, 1, 0); cycle(st, fl);
    drv(1, 1, 1, 1, 1, 1, 2, 1, 0, 0);
    #1;
    chk("pre_rst_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_fwdA", fa, 0);
    chk("mid_rst_scnt", sc, 0);
    chk("mid_rst_fcnt", fc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(st, fl);
    chk("post_rst_fwdA", fa, 0);
    chk("post_rst_fwdB", fb, 0);

    // Random traffic on a small register window to force frequent hazards
    for (int n = 0; n < 3000; n++) begin
      drv($urandom_range(9, 0) != 0, $urandom_range(4, 0) != 0,
          int'($urandom_range(3, 0)), $urandom_range(3, 0) != 0,
          int'($urandom_range(3, 0)), $urandom_range(1, 0) != 0,
          int'($urandom_range(3, 0)), $urandom_range(3, 0) != 0,
          $urandom_range(2, 0) == 0, $urandom_range(9, 0) == 0);
      cycle(st, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
